xvec2_vscale_vec_lsu: RTL and testbench

Vector load/store sequencer for the xvec2 extension. It takes one strided vector memory request from decode and issues one word access per active lane over the scalar dmem port. It runs these accesses sequentially, one outstanding at a time. For loads, it assembles the returned words into a full vector and drives the vector register file write port (wen/wa/wmask/wd) in a single write-back cycle. For stores, the store data comes from the vector register file read port, captured at request acceptance.

---
 rtl/xvec2_vscale_vec_lsu_pkg.sv | 34 +++
 rtl/xvec2_vscale_vec_lsu_lane_sel.sv | 24 ++
 rtl/xvec2_vscale_vec_lsu.sv | 106 ++++++++++
 tb/tb_xvec2_vscale_vec_lsu.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/xvec2_vscale_vec_lsu_pkg.sv
// Shared widths, FSM encoding, latched-request payload and lane-offset helper
// for the xvec2 vector load/store sequencer.
package xvec2_vscale_vec_lsu_pkg;

  localparam int unsigned XPR_LEN            = 32;
  localparam int unsigned VEC_SIZE           = 4;
  localparam int unsigned VEC_XPR_LEN        = VEC_SIZE * XPR_LEN;
  localparam int unsigned VEC_ADDR_WIDTH     = 3;
  localparam int unsigned VEC_LANE_IDX_WIDTH = 2;

  localparam logic [1:0] XVEC2_LSU_IDLE = 2'd0;
  localparam logic [1:0] XVEC2_LSU_ADDR = 2'd1;
  localparam logic [1:0] XVEC2_LSU_DATA = 2'd2;
  localparam logic [1:0] XVEC2_LSU_WB   = 2'd3;

  typedef struct packed {
    logic                      store;
    logic [XPR_LEN-1:0]        stride;
    logic [VEC_ADDR_WIDTH-1:0] vd;
    logic [VEC_SIZE-1:0]       mask;
    logic [VEC_XPR_LEN-1:0]    wdata;
  } lsu_req_t;

  // n*stride for a 2-bit lane distance, built from shift/add only
  function automatic logic [XPR_LEN-1:0] lane_offset(input logic [XPR_LEN-1:0] stride,
                                                     input logic [VEC_LANE_IDX_WIDTH-1:0] n);
    logic [XPR_LEN-1:0] one;
    logic [XPR_LEN-1:0] two;
    one = n[0] ? stride : '0;
    two = n[1] ? {stride[XPR_LEN-2:0], 1'b0} : '0;
    return one + two;
  endfunction

endpackage

// File: rtl/xvec2_vscale_vec_lsu_lane_sel.sv
// Finds the lowest set mask bit strictly above cur (or at/above 0 when first).
module xvec2_vscale_lane_sel
  import xvec2_vscale_vec_lsu_pkg::*;
(
  input  logic [VEC_SIZE-1:0]           mask,
  input  logic [VEC_LANE_IDX_WIDTH-1:0] cur,
  input  logic                          first,
  output logic                          found,
  output logic [VEC_LANE_IDX_WIDTH-1:0] idx
);

  // Descending scan so the lowest qualifying lane wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = int'(VEC_SIZE) - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur)))) begin
        found = 1'b1;
        idx   = VEC_LANE_IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/xvec2_vscale_vec_lsu.sv
// Strided vector load/store sequencer: one scalar dmem access per active lane,
// single-cycle vector register write-back for loads.
module xvec2_vscale_vec_lsu
  import xvec2_vscale_vec_lsu_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_store,
  input  logic [XPR_LEN-1:0]        req_base,
  input  logic [XPR_LEN-1:0]        req_stride,
  input  logic [VEC_ADDR_WIDTH-1:0] req_vd,
  input  logic [VEC_SIZE-1:0]       req_mask,
  input  logic [VEC_XPR_LEN-1:0]    req_wdata,
  output logic                      dmem_en,
  output logic                      dmem_wen,
  output logic [XPR_LEN-1:0]        dmem_addr,
  output logic [XPR_LEN-1:0]        dmem_wdata,
  input  logic [XPR_LEN-1:0]        dmem_rdata,
  input  logic                      dmem_wait,
  output logic                      vf_wen,
  output logic [VEC_ADDR_WIDTH-1:0] vf_wa,
  output logic [VEC_SIZE-1:0]       vf_wmask,
  output logic [VEC_XPR_LEN-1:0]    vf_wd,
  output logic                      busy,
  output logic                      done
);

  logic [1:0]                    state_q, state_d;
  logic [VEC_LANE_IDX_WIDTH-1:0] lane_q, sel_idx;
  logic [XPR_LEN-1:0]            acc_q;
  lsu_req_t                      req_q, req_in, req_cur;
  logic [VEC_SIZE-1:0]           sel_mask;
  logic                          sel_first, sel_found, accept, data_done;

  assign req_in    = '{store: req_store, stride: req_stride, vd: req_vd,
                       mask: req_mask, wdata: req_wdata};
  assign accept    = (state_q == XVEC2_LSU_IDLE) && req_valid;
  assign req_cur   = accept ? req_in : req_q;
  assign data_done = (state_q == XVEC2_LSU_DATA) && !dmem_wait;

  // In IDLE search the incoming mask from lane 0; otherwise search above lane_q
  assign sel_first = (state_q == XVEC2_LSU_IDLE);
  assign sel_mask  = sel_first ? req_mask : req_q.mask;

  xvec2_vscale_lane_sel u_lane_sel (
    .mask  (sel_mask),
    .cur   (lane_q),
    .first (sel_first),
    .found (sel_found),
    .idx   (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      XVEC2_LSU_IDLE: if (req_valid) state_d = sel_found ? XVEC2_LSU_ADDR : XVEC2_LSU_WB;
      XVEC2_LSU_ADDR: if (!dmem_wait) state_d = XVEC2_LSU_DATA;
      XVEC2_LSU_DATA: if (!dmem_wait) state_d = sel_found ? XVEC2_LSU_ADDR : XVEC2_LSU_WB;
      default:        state_d = XVEC2_LSU_IDLE;
    endcase
  end

  assign req_ready  = (state_q == XVEC2_LSU_IDLE);
  assign dmem_en    = (state_q == XVEC2_LSU_ADDR);
  assign dmem_wen   = dmem_en && req_q.store;
  assign dmem_addr  = {acc_q[XPR_LEN-1:2], 2'b00};
  assign dmem_wdata = req_q.wdata[{lane_q, 5'b0} +: XPR_LEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= XVEC2_LSU_IDLE;
      lane_q   <= '0;
      acc_q    <= '0;
      req_q    <= '0;
      vf_wd    <= '0;
      vf_wen   <= 1'b0;
      vf_wa    <= '0;
      vf_wmask <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q  <= req_in;
        vf_wd  <= '0;
        lane_q <= sel_idx;
        acc_q  <= req_base + lane_offset(req_stride, sel_idx);
      end else if (data_done) begin
        if (!req_q.store) vf_wd[{lane_q, 5'b0} +: XPR_LEN] <= dmem_rdata;
        // Skipped lanes still advance the address by one stride each
        if (sel_found) begin
          lane_q <= sel_idx;
          acc_q  <= acc_q + lane_offset(req_q.stride, sel_idx - lane_q);
        end
      end
      done     <= (state_d == XVEC2_LSU_WB);
      vf_wen   <= (state_d == XVEC2_LSU_WB) && !req_cur.store && (|req_cur.mask) && (|req_cur.vd);
      vf_wa    <= (state_d == XVEC2_LSU_WB) ? req_cur.vd : '0;
      vf_wmask <= (state_d == XVEC2_LSU_WB) ? req_cur.mask : '0;
      busy     <= (state_d != XVEC2_LSU_IDLE);
    end
  end

endmodule

// File: tb/tb_xvec2_vscale_vec_lsu.sv
// Directed, table-driven bench for the xvec2 vector load/store sequencer.
module tb_xvec2_vscale_vec_lsu;

  typedef struct packed {
    logic          store;
    logic [31:0]   base;
    logic [31:0]   stride;
    logic [2:0]    vd;
    logic [3:0]    mask;
    logic [127:0]  wdata;
    logic [63:0]   wait_sched;
    logic [31:0]   exp_n;
    logic [3:0][31:0] exp_addr;
    logic [3:0][31:0] exp_data;
    logic [31:0]   exp_wb;
    logic          exp_wen;
    logic [127:0]  exp_wd;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_store;
  logic [31:0]  req_base, req_stride;
  logic [2:0]   req_vd;
  logic [3:0]   req_mask;
  logic [127:0] req_wdata;
  logic         dmem_en, dmem_wen, dmem_wait;
  logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic         vf_wen;
  logic [2:0]   vf_wa;
  logic [3:0]   vf_wmask;
  logic [127:0] vf_wd;
  logic         busy, done;

  logic [31:0]  last_addr;
  int           n_checks = 0;
  int           n_fail   = 0;
  vec_t         vecs [7];

  always #5 clk = ~clk;

  xvec2_vscale_vec_lsu dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_base(req_base), .req_stride(req_stride), .req_vd(req_vd),
    .req_mask(req_mask), .req_wdata(req_wdata),
    .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_wait(dmem_wait),
    .vf_wen(vf_wen), .vf_wa(vf_wa), .vf_wmask(vf_wmask), .vf_wd(vf_wd),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return {16'hD000, a[15:0]};
    endcase
  endfunction

  always_comb dmem_rdata = mem_word(last_addr);

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int  n_acc;
    bit  pend, seen;
    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", id), 128'(req_ready), 128'(1));
    req_valid = 1'b1; req_store = v.store; req_base = v.base; req_stride = v.stride;
    req_vd = v.vd; req_mask = v.mask; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wdata = '1; req_mask = '1; req_base = '1; req_stride = '1; req_vd = '1;
    n_acc = 0; pend = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      dmem_wait = v.wait_sched[c];
      if (pend && !dmem_wait) begin
        if (v.store) chk($sformatf("v%0d_st_data%0d", id, n_acc - 1), 128'(dmem_wdata),
                         128'(v.exp_data[n_acc-1]));
        pend = 1'b0;
      end
      if (dmem_en) begin
        last_addr = dmem_addr;
        if (n_acc >= int'(v.exp_n)) begin
          chk($sformatf("v%0d_extra_access", id), 128'(dmem_addr), 128'(0) - 128'(1));
        end else begin
          chk($sformatf("v%0d_addr%0d", id, n_acc), 128'(dmem_addr), 128'(v.exp_addr[n_acc]));
          chk($sformatf("v%0d_wen%0d", id, n_acc), 128'(dmem_wen), 128'(v.store));
        end
        if (!dmem_wait) begin n_acc++; pend = 1'b1; end
      end
      if (vf_wen && !done) chk($sformatf("v%0d_vf_wen_outside_wb", id), 128'(vf_wen), 128'(0));
      if (done) begin
        seen = 1'b1;
        chk($sformatf("v%0d_wb_cycle", id), 128'(c), 128'(v.exp_wb));
        chk($sformatf("v%0d_vf_wen", id), 128'(vf_wen), 128'(v.exp_wen));
        chk($sformatf("v%0d_vf_wa", id), 128'(vf_wa), 128'(v.vd));
        chk($sformatf("v%0d_vf_wmask", id), 128'(vf_wmask), 128'(v.mask));
        chk($sformatf("v%0d_vf_wd", id), vf_wd, v.exp_wd);
        chk($sformatf("v%0d_busy_wb", id), 128'(busy), 128'(1));
      end
    end
    dmem_wait = 1'b0;
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL v%0d_done_timeout: got no done expected done at cycle %0d", id, v.exp_wb);
    end
    chk($sformatf("v%0d_n_access", id), 128'(n_acc), 128'(v.exp_n));
    @(negedge clk);
    chk($sformatf("v%0d_ready_after", id), 128'({req_ready, busy, done, vf_wen}), 128'(4'b1000));
  endtask

  initial begin
    vecs[0] = '{store: 1'b0, base: 32'h100, stride: 32'd4, vd: 3'd2, mask: 4'b1111, wdata: '0,
                wait_sched: '0, exp_n: 32'd4,
                exp_addr: {32'h10C, 32'h108, 32'h104, 32'h100}, exp_data: '0,
                exp_wb: 32'd9, exp_wen: 1'b1,
                exp_wd: {32'h44, 32'h33, 32'h22, 32'h11}};
    vecs[1] = '{store: 1'b1, base: 32'h200, stride: 32'd16, vd: 3'd3, mask: 4'b0101,
                wdata: {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001},
                wait_sched: '0, exp_n: 32'd2,
                exp_addr: {32'h0, 32'h0, 32'h220, 32'h200},
                exp_data: {32'h0, 32'h0, 32'hCCCC0003, 32'hAAAA0001},
                exp_wb: 32'd5, exp_wen: 1'b0, exp_wd: '0};
    vecs[2] = '{store: 1'b0, base: 32'h300, stride: 32'd4, vd: 3'd1, mask: 4'b0000, wdata: '0,
                wait_sched: '0, exp_n: 32'd0, exp_addr: '0, exp_data: '0,
                exp_wb: 32'd1, exp_wen: 1'b0, exp_wd: '0};
    vecs[3] = '{store: 1'b0, base: 32'h100, stride: 32'd4, vd: 3'd5, mask: 4'b0001, wdata: '0,
                wait_sched: 64'h6E, exp_n: 32'd1,
                exp_addr: {32'h0, 32'h0, 32'h0, 32'h100}, exp_data: '0,
                exp_wb: 32'd8, exp_wen: 1'b1, exp_wd: {96'h0, 32'h11}};
    vecs[4] = '{store: 1'b0, base: 32'h10, stride: 32'hFFFF_FFFC, vd: 3'd0, mask: 4'b1111,
                wdata: '0, wait_sched: '0, exp_n: 32'd4,
                exp_addr: {32'h04, 32'h08, 32'h0C, 32'h10}, exp_data: '0,
                exp_wb: 32'd9, exp_wen: 1'b0,
                exp_wd: {32'hD0000004, 32'hD0000008, 32'hD000000C, 32'hD0000010}};
    vecs[5] = '{store: 1'b0, base: 32'h100, stride: 32'd4, vd: 3'd7, mask: 4'b1010, wdata: '0,
                wait_sched: '0, exp_n: 32'd2,
                exp_addr: {32'h0, 32'h0, 32'h10C, 32'h104}, exp_data: '0,
                exp_wb: 32'd5, exp_wen: 1'b1,
                exp_wd: {32'h44, 32'h0, 32'h22, 32'h0}};
    vecs[6] = '{store: 1'b0, base: 32'h102, stride: 32'd4, vd: 3'd4, mask: 4'b0001, wdata: '0,
                wait_sched: '0, exp_n: 32'd1,
                exp_addr: {32'h0, 32'h0, 32'h0, 32'h100}, exp_data: '0,
                exp_wb: 32'd3, exp_wen: 1'b1, exp_wd: {96'h0, 32'h11}};

    reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_stride = '0;
    req_vd = '0; req_mask = '0; req_wdata = '0; dmem_wait = 1'b0; last_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 128'(req_ready), 128'(1));
    chk("reset_ctrl", 128'({busy, done, dmem_en, dmem_wen, vf_wen, vf_wa, vf_wmask}), 128'(0));
    chk("reset_data", {dmem_addr, dmem_wdata, 64'h0} | vf_wd, 128'(0));
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort a load during lane-1 DATA
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_base = 32'h100; req_stride = 32'd4;
    req_vd = 3'd2; req_mask = 4'b1111; req_wdata = '0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_before", 128'({busy, dmem_en}), 128'(2'b10));
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 128'(req_ready), 128'(1));
    chk("mid_rst_ctrl", 128'({busy, done, dmem_en, dmem_wen, vf_wen, vf_wa, vf_wmask}), 128'(0));
    chk("mid_rst_addr", 128'(dmem_addr), 128'(0));
    chk("mid_rst_wdata", 128'(dmem_wdata), 128'(0));
    chk("mid_rst_vf_wd", vf_wd, 128'(0));
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen_activity;
      seen_activity = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || vf_wen || busy || dmem_en) seen_activity++;
      end
      chk("mid_rst_no_pulse", 128'(seen_activity), 128'(0));
    end
    run_vec(7, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
